// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin front end sharing one single-port SRAM among
// NUM_CH request channels. A tag FIFO routes in-order read returns back.
// Ports: clk/rst_n (async active-low); ch_req/ch_we/ch_addr/ch_wdata/ch_wmask
// in, ch_gnt (comb one-hot), ch_rvalid/ch_rdata (registered returns) out;
// sram_rd_* / sram_wr_* / sram_w_mask downstream port, sram_rd_valid/data
// returns; outstanding = reads in flight; err_unexp_rvalid sticky error.
module sram_rr_arbiter #(
   parameter int NUM_CH          = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_OF_BYTES    = DATA_WIDTH/8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CH-1:0]                      ch_req,
   input  logic [NUM_CH-1:0]                      ch_we,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]           ch_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]           ch_wdata,
   input  logic [NUM_CH*NUM_OF_BYTES-1:0]         ch_wmask,
   output logic [NUM_CH-1:0]                      ch_gnt,
   output logic [NUM_CH-1:0]                      ch_rvalid,
   output logic [DATA_WIDTH-1:0]                  ch_rdata,
   output logic                                   sram_rd_en,
   output logic [ADDR_WIDTH-1:0]                  sram_rd_addr,
   input  logic                                   sram_rd_valid,
   input  logic [DATA_WIDTH-1:0]                  sram_rd_data,
   output logic                                   sram_wr_en,
   output logic [ADDR_WIDTH-1:0]                  sram_wr_addr,
   output logic [DATA_WIDTH-1:0]                  sram_wr_data,
   output logic [NUM_OF_BYTES-1:0]                sram_w_mask,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   err_unexp_rvalid
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]       tag_mem_q [MAX_OUTSTANDING];
   logic [CH_W-1:0]       tag_mem_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_CH-1:0]     ch_rvalid_q, ch_rvalid_d;
   logic [DATA_WIDTH-1:0] ch_rdata_q, ch_rdata_d;
   logic                  err_q, err_d;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  gnt_any;
   logic [CH_W-1:0]       gnt_idx;
   logic [NUM_CH-1:0]     elig;
   logic [CH_W:0]         scan;

   // Full/empty come from the registered count: a pop in the same
   // cycle never frees a slot for a read grant.
   assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);

   // rst_n gates eligibility so nothing is granted while in reset.
   assign elig = ch_req
               & (ch_we | {NUM_CH{~fifo_full}})
               & {NUM_CH{rst_n}};

   // Scan from rr_ptr upward, wrapping at NUM_CH; first hit wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
         if (scan >= (CH_W+1)'(NUM_CH))
            scan = scan - (CH_W+1)'(NUM_CH);
         if (!gnt_any && elig[scan[CH_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[CH_W-1:0];
         end
      end
   end

   always_comb begin
      ch_gnt = '0;
      if (gnt_any)
         ch_gnt[gnt_idx] = 1'b1;
   end

   // gnt_idx is 0 with no grant, so idle buses mirror channel 0.
   assign sram_rd_en   = gnt_any & ~ch_we[gnt_idx];
   assign sram_wr_en   = gnt_any &  ch_we[gnt_idx];
   assign sram_rd_addr = ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sram_wr_addr = ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sram_wr_data = ch_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sram_w_mask  = ch_wmask[gnt_idx*NUM_OF_BYTES +: NUM_OF_BYTES];

   assign push = sram_rd_en;
   assign pop  = sram_rd_valid & ~fifo_empty;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      tag_mem_d   = tag_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      ch_rvalid_d = '0;
      ch_rdata_d  = ch_rdata_q;
      err_d       = err_q | (sram_rd_valid & fifo_empty);

      if (gnt_any)
         rr_ptr_d = (gnt_idx == CH_W'(NUM_CH-1)) ? '0
                                                 : gnt_idx + CH_W'(1);

      if (push) begin
         tag_mem_d[wr_ptr_q] = gnt_idx;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         ch_rvalid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
         ch_rdata_d = sram_rd_data;
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end

      unique case (1'b1)
         push && !pop: cnt_d = cnt_q + CNT_W'(1);
         pop && !push: cnt_d = cnt_q - CNT_W'(1);
         default:      cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ch_rvalid_q <= '0;
         ch_rdata_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++)
            tag_mem_q[i] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ch_rvalid_q <= ch_rvalid_d;
         ch_rdata_q  <= ch_rdata_d;
         err_q       <= err_d;
         tag_mem_q   <= tag_mem_d;
      end
   end

   assign ch_rvalid        = ch_rvalid_q;
   assign ch_rdata         = ch_rdata_q;
   assign outstanding      = cnt_q;
   assign err_unexp_rvalid = err_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based behavioural model of the arbiter.
module tb_sram_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NB = DW/8;
   localparam int MO = 4;
   localparam int CW = $clog2(MO+1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      ch_req = '0;
   logic [N-1:0]      ch_we = '0;
   logic [N*AW-1:0]   ch_addr;
   logic [N*DW-1:0]   ch_wdata;
   logic [N*NB-1:0]   ch_wmask;
   logic [N-1:0]      ch_gnt;
   logic [N-1:0]      ch_rvalid;
   logic [DW-1:0]     ch_rdata;
   logic              sram_rd_en;
   logic [AW-1:0]     sram_rd_addr;
   logic              sram_rd_valid = 1'b0;
   logic [DW-1:0]     sram_rd_data = '0;
   logic              sram_wr_en;
   logic [AW-1:0]     sram_wr_addr;
   logic [DW-1:0]     sram_wr_data;
   logic [NB-1:0]     sram_w_mask;
   logic [CW-1:0]     outstanding;
   logic              err_unexp_rvalid;

   logic [AW-1:0]     a_v [N];
   logic [DW-1:0]     d_v [N];
   logic [NB-1:0]     m_v [N];

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign ch_addr[i*AW +: AW]  = a_v[i];
      assign ch_wdata[i*DW +: DW] = d_v[i];
      assign ch_wmask[i*NB +: NB] = m_v[i];
   end

   sram_rr_arbiter #(
      .NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .NUM_OF_BYTES(NB), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_wmask(ch_wmask),
      .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
      .sram_rd_valid(sram_rd_valid), .sram_rd_data(sram_rd_data),
      .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
      .sram_wr_data(sram_wr_data), .sram_w_mask(sram_w_mask),
      .outstanding(outstanding), .err_unexp_rvalid(err_unexp_rvalid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int            rr;
   int            tagq [$];
   logic          err_m;
   logic [N-1:0]  rv_m;
   logic [DW-1:0] rd_m;
   int            g_m;
   int            cyc = 0;

   // SRAM-side model: reads issued and not yet returned
   logic [AW-1:0] saddr_q [$];
   int            scyc_q [$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Called with inputs driven just after a posedge.
   task automatic eval();
      #1;
      g_m = -1;
      for (int k = 0; k < N; k++) begin
         int i = (rr + k) % N;
         if (g_m < 0 && ch_req[i] && (ch_we[i] || tagq.size() < MO))
            g_m = i;
      end
      chk("gnt", ch_gnt, (g_m < 0) ? 0 : (1 << g_m));
      chk("rd_en", sram_rd_en, (g_m >= 0) && !ch_we[g_m]);
      chk("wr_en", sram_wr_en, (g_m >= 0) && ch_we[g_m]);
      if (g_m >= 0 && !ch_we[g_m])
         chk("rd_addr", sram_rd_addr, a_v[g_m]);
      if (g_m >= 0 && ch_we[g_m]) begin
         chk("wr_addr", sram_wr_addr, a_v[g_m]);
         chk("wr_data", sram_wr_data, d_v[g_m]);
         chk("w_mask", sram_w_mask, m_v[g_m]);
      end
   endtask

   task automatic commit();
      rv_m = '0;
      if (sram_rd_valid) begin
         if (tagq.size() > 0) begin
            int h = tagq.pop_front();
            rv_m = N'(1 << h);
            rd_m = sram_rd_data;
         end else begin
            err_m = 1'b1;
         end
         if (saddr_q.size() > 0) begin
            void'(saddr_q.pop_front());
            void'(scyc_q.pop_front());
         end
      end
      if (g_m >= 0 && !ch_we[g_m]) begin
         tagq.push_back(g_m);
         saddr_q.push_back(a_v[g_m]);
         scyc_q.push_back(cyc);
      end
      if (g_m >= 0)
         rr = (g_m + 1) % N;
      @(posedge clk);
      #1;
      cyc++;
      chk("rvalid", ch_rvalid, rv_m);
      if (rv_m != '0)
         chk("rdata", ch_rdata, rd_m);
      chk("outst", outstanding, tagq.size());
      chk("err", err_unexp_rvalid, err_m);
   endtask

   // Return the oldest read if at least lat cycles old, with pct chance.
   task automatic set_ret(input int pct, input int lat);
      sram_rd_valid = (saddr_q.size() > 0)
                   && (cyc - scyc_q[0] >= lat)
                   && ($urandom_range(0, 99) < pct);
      sram_rd_data = sram_rd_valid ? saddr_q[0] + 1 : $urandom;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ch_req = '1;
      ch_we = '0;
      sram_rd_valid = 1'b0;
      #2;
      chk("rst_gnt", ch_gnt, 0);
      chk("rst_rd_en", sram_rd_en, 0);
      chk("rst_wr_en", sram_wr_en, 0);
      chk("rst_rvalid", ch_rvalid, 0);
      chk("rst_rdata", ch_rdata, 0);
      chk("rst_outst", outstanding, 0);
      chk("rst_err", err_unexp_rvalid, 0);
      tagq.delete();
      rr = 0;
      err_m = 1'b0;
      rv_m = '0;
      rd_m = '0;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      ch_req = '0;
   endtask

   task automatic drain();
      ch_req = '0;
      for (int c = 0; c < 40 && saddr_q.size() > 0; c++) begin
         set_ret(100, 0);
         eval();
         commit();
      end
      sram_rd_valid = 1'b0;
      chk("drain", outstanding, 0);
   endtask

   int peak;

   initial begin
      for (int i = 0; i < N; i++) begin
         a_v[i] = '0;
         d_v[i] = '0;
         m_v[i] = '0;
      end
      #1;
      do_reset();

      // all channels read continuously, SRAM latency 2
      ch_req = '1;
      ch_we = '0;
      for (int i = 0; i < N; i++)
         a_v[i] = AW'(32'h10 * i);
      peak = 0;
      for (int k = 0; k < 12; k++) begin
         set_ret(100, 2);
         eval();
         chk("tp1_gnt", ch_gnt, 1 << (k % N));
         commit();
         if (int'(outstanding) > peak)
            peak = int'(outstanding);
      end
      chk("tp1_peak", peak, 2);
      drain();

      // lone write on channel 2
      ch_req = 4'b0100;
      ch_we = 4'b0100;
      a_v[2] = 32'h40;
      d_v[2] = 32'hDEADBEEF;
      m_v[2] = 4'b0101;
      eval();
      chk("tp2_wr_en", sram_wr_en, 1);
      chk("tp2_wr_addr", sram_wr_addr, 32'h40);
      chk("tp2_mask", sram_w_mask, 4'b0101);
      chk("tp2_rd_en", sram_rd_en, 0);
      commit();
      ch_req = '1;
      ch_we = '1;
      eval();
      chk("tp2_rr3", ch_gnt, 4'b1000);
      commit();
      ch_req = '0;
      ch_we = '0;

      // fill the tag FIFO with channel 0 reads
      ch_req = 4'b0001;
      a_v[0] = 32'h100;
      sram_rd_valid = 1'b0;
      for (int k = 0; k < MO; k++) begin
         eval();
         commit();
      end
      chk("tp3_full", outstanding, MO);
      ch_req = 4'b0011;
      ch_we = 4'b0010;
      eval();
      chk("tp3_wr_gnt", ch_gnt, 4'b0010);
      commit();
      ch_req = 4'b0001;
      ch_we = '0;
      set_ret(100, 0);
      eval();
      chk("tp4_nobypass", ch_gnt, 0);
      commit();
      chk("tp4_out3", outstanding, MO - 1);
      sram_rd_valid = 1'b0;
      eval();
      chk("tp3_5th", ch_gnt, 4'b0001);
      commit();
      drain();

      // unexpected return
      sram_rd_valid = 1'b1;
      sram_rd_data = 32'h5A5A5A5A;
      eval();
      commit();
      chk("tp5_rvalid", ch_rvalid, 0);
      chk("tp5_err", err_unexp_rvalid, 1);
      sram_rd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         eval();
         commit();
      end
      do_reset();

      // reset with two reads in flight, then stale returns
      ch_req = 4'b0011;
      ch_we = '0;
      a_v[1] = 32'h200;
      for (int k = 0; k < 2; k++) begin
         eval();
         commit();
      end
      chk("tp6_out2", outstanding, 2);
      do_reset();
      for (int k = 0; k < 2; k++) begin
         set_ret(100, 0);
         eval();
         commit();
         chk("tp6_stale", ch_rvalid, 0);
      end
      sram_rd_valid = 1'b0;
      chk("tp6_err", err_unexp_rvalid, 1);
      ch_req = 4'b1110;
      ch_we = 4'b1110;
      eval();
      chk("tp6_first", ch_gnt, 4'b0010);
      commit();
      ch_req = '0;
      ch_we = '0;
      saddr_q.delete();
      scyc_q.delete();
      do_reset();

      // randomized traffic; pct 0 blocks stall the SRAM side
      for (int blk = 0; blk < 10; blk++) begin
         int pct = (blk % 3 == 0) ? 0 : int'($urandom_range(20, 100));
         for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
               if (!ch_req[i] && $urandom_range(0, 2) == 0) begin
                  ch_req[i] = 1'b1;
                  ch_we[i] = ($urandom_range(0, 2) == 0);
                  a_v[i] = $urandom;
                  d_v[i] = $urandom;
                  m_v[i] = NB'($urandom);
               end
            end
            set_ret(pct, 1);
            eval();
            commit();
            if (g_m >= 0)
               ch_req[g_m] = 1'b0;
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Parametrised multi-channel front end for one shared single-port SRAM. It arbitrates NUM_CH request channels (fetch, LSU, debug, ...) round-robin onto one downstream read/write port with byte write mask.
- Accepts in-order read returns of variable latency from the SRAM side. A tag FIFO routes each return to the channel that issued the read.
- Generalises the single-master SRAM port to N masters with outstanding-read tracking.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- NUM_OF_BYTES, DATA_WIDTH/8, write-mask width
- MAX_OUTSTANDING, 4, maximum reads in flight (tag FIFO depth, power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  per-channel request valid
- ch_we  in  NUM_CH  1 = write, 0 = read
- ch_addr  in  NUM_CH*ADDR_WIDTH  per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data
- ch_wmask  in  NUM_CH*NUM_OF_BYTES  per-channel byte enables
- ch_gnt  out  NUM_CH  one-hot grant, combinational, same cycle as accept
- ch_rvalid  out  NUM_CH  one-hot read-return strobe, registered
- ch_rdata  out  DATA_WIDTH  read data shared by all channels, qualified by ch_rvalid
- sram_rd_en  out  1  downstream read strobe
- sram_rd_addr  out  ADDR_WIDTH  downstream read address
- sram_rd_valid  in  1  downstream read data valid
- sram_rd_data  in  DATA_WIDTH  downstream read data
- sram_wr_en  out  1  downstream write strobe
- sram_wr_addr  out  ADDR_WIDTH  downstream write address
- sram_wr_data  out  DATA_WIDTH  downstream write data
- sram_w_mask  out  NUM_OF_BYTES  downstream byte mask
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
- err_unexp_rvalid  out  1  sticky: sram_rd_valid arrived with no read in flight

Behaviour:
- Reset (rst_n low, async):
  - rr_ptr=0, FIFO empty, outstanding=0, err_unexp_rvalid=0, ch_rvalid=0, ch_rdata=0.
  - sram_rd_en=0, sram_wr_en=0 (combinational, forced by no grant while in reset).
- Eligibility:
  - Channel i is eligible if ch_req[i] and (ch_we[i] or outstanding < MAX_OUTSTANDING).
  - A full FIFO blocks reads only. Writes always proceed.
  - The full check uses the registered count. A same-cycle pop does not free a slot.
- Arbitration:
  - Round-robin among eligible channels, searching from rr_ptr upward with wrap NUM_CH-1 -> 0.
  - At most one grant per cycle. ch_gnt is combinational.
- Pointer update: on any grant to channel g, rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Downstream drive (combinational from the granted channel, same cycle as grant):
  - Write grant: sram_wr_en=1, wr_addr/wr_data/w_mask from channel g, sram_rd_en=0.
  - Read grant: sram_rd_en=1, rd_addr from channel g, sram_wr_en=0.
  - With no grant, both enables are 0. Address and data are don't-care but driven from channel 0, with no X.
- Tag FIFO push: on a read grant, push g.
- Tag FIFO pop: on sram_rd_valid with FIFO non-empty, pop head h. Next cycle: ch_rvalid[h]=1, ch_rdata=sram_rd_data. Read return latency is 1 cycle after sram_rd_valid.
- Simultaneous push and pop: both occur, count unchanged. Pointers wrap mod MAX_OUTSTANDING.
- Unexpected return: sram_rd_valid with FIFO empty. Data is dropped, ch_rvalid stays 0, err_unexp_rvalid <= 1 and stays set until reset.
- Ordering: the SRAM side returns reads in issue order. No reordering is supported.
- Requester contract: a channel holds req, we, addr, wdata and wmask stable until ch_gnt. Arbitration does not depend on channel stability.
- Reset mid-operation: in-flight tags are discarded. Returns arriving after reset release set err_unexp_rvalid.

Test Plan:
- NUM_CH=4, all four channels read addr 0x10*i continuously from reset; SRAM returns data = addr+1 two cycles later -> grants 0,1,2,3,0,... cycle by cycle; ch_rvalid[i] carries 0x10*i+1 in issue order; outstanding peaks at 2.
- Channel 2 writes 0xDEADBEEF, mask 4'b0101, addr 0x40, alone -> same cycle: sram_wr_en=1, sram_wr_addr=0x40, sram_w_mask=4'b0101; rr_ptr becomes 3.
- MAX_OUTSTANDING=4, SRAM withholds rd_valid; channel 0 reads 5 times while channel 1 writes once -> 4 reads granted, outstanding=4; then channel 1's write is granted while channel 0 is blocked; after one rd_valid, channel 0's 5th read is granted the following cycle.
- Single rd_valid in the same cycle as a new read grant while outstanding=4 -> the read is not granted that cycle (no bypass); outstanding=3 next cycle.
- sram_rd_valid pulsed with outstanding=0 -> ch_rvalid stays 0; err_unexp_rvalid=1 and persists until rst_n low.
- rst_n asserted while outstanding=2, released, then 2 stale rd_valids -> no ch_rvalid; err_unexp_rvalid=1; rr_ptr=0 so the first new grant goes to the lowest requesting channel.
